pulse_len_tx: RTL and testbench

Short/long pulse transmitter; the sending end of the press-duration link whose receiver classifies a level pulse as short or long by tick count.
- Takes a packed symbol word and a symbol count from a controller.
- Drives pulse_out high for SHORT_TICKS or LONG_TICKS ticks per symbol, separated by GAP_TICKS low ticks.
- Used to drive an LED or the receiver input for loopback test.

---
 rtl/pulse_len_tx.sv | 129 ++++++++++++
 tb/tb_pulse_len_tx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_len_tx.sv
// Short/long pulse transmitter: sends a packed word of short/long level pulses.
// Optional ABORT_EN macro adds an abort input that ends a transfer early.
module pulse_len_tx #(
  parameter int TICK_DIV    = 6510,
  parameter int SHORT_TICKS = 1920,
  parameter int LONG_TICKS  = 5760,
  parameter int GAP_TICKS   = 1920,
  parameter int MAX_SYM     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_SYM-1:0] sym_bits,
  input  logic [4:0]         sym_count,
`ifdef ABORT_EN
  input  logic               abort,
`endif
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               pulse_out
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (LONG_TICKS > GAP_TICKS) ? LONG_TICKS
                                                 : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = (MAX_SYM > 1) ? $clog2(MAX_SYM) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PULSE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [MAX_SYM-1:0] sym_q, sym_d;
  logic [4:0]         cnt_q, cnt_d;

  logic          tick;
  logic          last;
  logic          abort_w;
  logic [TW-1:0] target;
  logic [4:0]    req_cnt;

`ifdef ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign last    = ((5'(idx_q) + 5'd1) == cnt_q);
  assign target  = sym_q[idx_q] ? TW'(LONG_TICKS)
                                : TW'(SHORT_TICKS);
  assign req_cnt = (sym_count > 5'(MAX_SYM)) ? 5'(MAX_SYM)
                                             : sym_count;

  always_comb begin
    state_d = state_q;
    presc_d = tick ? '0 : presc_q + 1'b1;
    tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
    idx_d   = idx_q;
    sym_d   = sym_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        presc_d = '0;
        tcnt_d  = '0;
        if (start) begin
          sym_d   = sym_bits;
          cnt_d   = req_cnt;
          idx_d   = '0;
          state_d = (req_cnt == 5'd0) ? S_DONE : S_PULSE;
        end
      end
      S_PULSE: begin
        if (tick && (tcnt_q == target - 1'b1)) begin
          if (last) begin
            state_d = S_DONE;
          end else begin
            state_d = S_GAP;
            idx_d   = idx_q + 1'b1;
          end
        end
        if (abort_w) state_d = S_DONE;
      end
      S_GAP: begin
        if (tick && (tcnt_q == TW'(GAP_TICKS - 1)))
          state_d = S_PULSE;
        if (abort_w) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    // every segment starts from a clean prescaler and tick count
    if (state_d != state_q) begin
      presc_d = '0;
      tcnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      idx_q   <= '0;
      sym_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      sym_q   <= sym_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready     = (state_q == S_IDLE);
  assign busy      = (state_q == S_PULSE) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign pulse_out = (state_q == S_PULSE);

endmodule

// File: tb/tb_pulse_len_tx.sv
// Bench for pulse_len_tx: queue-based waveform model plus directed scenarios.
// Define ABORT_EN to also exercise the abort input.
module tb_pulse_len_tx;
  localparam int TD = 4;
  localparam int ST = 2;
  localparam int LT = 5;
  localparam int GT = 3;
  localparam int MS = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] sym_bits = '0;
  logic [4:0] sym_count = '0;
`ifdef ABORT_EN
  logic       abort = 1'b0;
`endif
  logic ready, busy, done, pulse_out;

  always #5 clk = ~clk;

  pulse_len_tx #(
    .TICK_DIV(TD), .SHORT_TICKS(ST), .LONG_TICKS(LT),
    .GAP_TICKS(GT), .MAX_SYM(MS)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .sym_bits(sym_bits), .sym_count(sym_count),
`ifdef ABORT_EN
    .abort(abort),
`endif
    .ready(ready), .busy(busy), .done(done),
    .pulse_out(pulse_out)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t",
               name, act, exp, $time);
    end
  endtask

  // expected per-cycle outputs: {pulse, done, busy}
  typedef struct packed {
    logic p;
    logic d;
    logic b;
  } exp_t;
  localparam exp_t E_HI   = 3'b101;
  localparam exp_t E_GAP  = 3'b001;
  localparam exp_t E_DONE = 3'b010;

  exp_t q[$];
  exp_t mf;
  exp_t ce;
  bit   m_empty;

  function automatic void build(logic [7:0] b, logic [4:0] c);
    int n;
    int len;
    n = (int'(c) > MS) ? MS : int'(c);
    for (int i = 0; i < n; i++) begin
      len = b[i] ? LT : ST;
      for (int k = 0; k < len * TD; k++) q.push_back(E_HI);
      if (i < n - 1)
        for (int k = 0; k < GT * TD; k++) q.push_back(E_GAP);
    end
    q.push_back(E_DONE);
  endfunction

  always @(negedge reset) q.delete();

  always @(posedge clk) begin
    if (reset) begin
      m_empty = (q.size() == 0);
      if (!m_empty) begin
        mf = q.pop_front();
`ifdef ABORT_EN
        if (abort && mf.b) begin
          q.delete();
          q.push_back(E_DONE);
        end
`endif
      end
      if (m_empty && start) build(sym_bits, sym_count);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      ce = (q.size() != 0) ? q[0] : 3'b000;
      chk("pulse_out", int'(pulse_out), int'(ce.p));
      chk("done", int'(done), int'(ce.d));
      chk("busy", int'(busy), int'(ce.b));
      chk("ready", int'(ready), int'(!(ce.b || ce.d)));
    end
  end

  // run-length recorder of pulse_out while busy
  int runs[$];
  int run = 0;
  logic lvl = 1'b1;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      run = 0;
      lvl = 1'b1;
    end else begin
      if (busy) begin
        if (pulse_out == lvl) run++;
        else begin
          runs.push_back(run);
          lvl = pulse_out;
          run = 1;
        end
      end
      if (done) begin
        if (run > 0) runs.push_back(run);
        run = 0;
        lvl = 1'b1;
        done_cnt++;
      end
    end
  end

  task automatic clr();
    runs.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] b, input logic [4:0] c);
    int i;
    for (i = 0; i < 500 && !ready; i++) @(negedge clk);
    chk("ready_wait", int'(ready), 1);
    @(posedge clk);
    #2;
    start = 1'b1;
    sym_bits = b;
    sym_count = c;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) @(negedge clk);
    chk("done_seen", int'(done_cnt > 0), 1);
    @(negedge clk);
  endtask

  task automatic chk_runs(string name, input int e[]);
    chk({name, "_nruns"}, runs.size(), e.size());
    for (int i = 0; i < e.size() && i < runs.size(); i++)
      chk($sformatf("%s_run%0d", name, i), runs[i], e[i]);
  endtask

  int hi;
  int sum;
  int nl;

  initial begin
    #1;
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pulse", int'(pulse_out), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // single short pulse
    clr();
    send(8'h00, 5'd1);
    hi = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      hi += int'(pulse_out);
    end
    chk("t1_high", hi, 8);
    @(negedge clk);
    chk("t1_done", int'(done), 1);
    chk("t1_fall", int'(pulse_out), 0);
    @(negedge clk);
    chk("t1_ready", int'(ready), 1);
    chk("t1_ndone", done_cnt, 1);

    // mixed 101
    clr();
    send(8'b101, 5'd3);
    wait_done(1000);
    chk_runs("t2", '{20, 12, 8, 12, 20});
    sum = 0;
    foreach (runs[i]) sum += runs[i];
    chk("t2_total", sum, 72);

    // zero count
    clr();
    send(8'hFF, 5'd0);
    @(negedge clk);
    chk("t3_zdone", int'(done), 1);
    chk("t3_zpulse", int'(pulse_out), 0);
    @(negedge clk);
    chk("t3_zready", int'(ready), 1);
    chk("t3_zruns", runs.size(), 0);

    // clamp to MAX_SYM
    clr();
    send(8'hFF, 5'd20);
    wait_done(2000);
    chk("t3_cruns", runs.size(), 15);
    nl = 0;
    foreach (runs[i]) if (runs[i] == 20) nl++;
    chk("t3_clong", nl, 8);

    // busy protection
    clr();
    send(8'b101, 5'd3);
    repeat (4) @(posedge clk);
    #2;
    start = 1'b1;
    sym_bits = 8'hFF;
    sym_count = 5'd1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(1000);
    chk_runs("t4", '{20, 12, 8, 12, 20});
    repeat (5) @(negedge clk);
    chk("t4_ndone", done_cnt, 1);

    // async reset during second pulse
    clr();
    send(8'b101, 5'd3);
    for (int i = 0; i < 200 && runs.size() < 2; i++)
      @(negedge clk);
    chk("t5_reach", int'(runs.size() >= 2), 1);
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_pulse", int'(pulse_out), 0);
    chk("t5_ready", int'(ready), 1);
    chk("t5_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_nodone", done_cnt, 0);
    chk("t5_ready2", int'(ready), 1);
    clr();
    send(8'h00, 5'd1);
    wait_done(200);
    chk_runs("t5_new", '{8});

`ifdef ABORT_EN
    clr();
    send(8'b101, 5'd3);
    for (int i = 0; i < 200 && runs.size() < 1; i++)
      @(negedge clk);
    @(posedge clk);
    #2 abort = 1'b1;
    @(posedge clk);
    #2 abort = 1'b0;
    @(negedge clk);
    chk("t6_done", int'(done), 1);
    chk("t6_pulse", int'(pulse_out), 0);
    @(negedge clk);
    chk("t6_ready", int'(ready), 1);
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      hi += int'(pulse_out);
    end
    chk("t6_nopulse", hi, 0);
    chk("t6_ndone", done_cnt, 1);
`endif

    // randomized requests
    for (int r = 0; r < 20; r++) begin
      clr();
      send(8'($urandom), 5'($urandom_range(0, 10)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 20)) @(posedge clk);
        #2;
        start = 1'b1;
        sym_bits = 8'($urandom);
        @(posedge clk);
        #2 start = 1'b0;
      end
`ifdef ABORT_EN
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 60)) @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
      end
`endif
      wait_done(2000);
      chk("rnd_ndone", done_cnt, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
